// File: rtl/operand_shifter_if.sv
// Operand-2 request/response bundle between decode, the operand shifter and the ALU.
// slave is the shifter's view; master is the view of whatever drives and consumes it.
interface operand_shifter_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_imm;
  logic [11:0] in_op2;
  logic [31:0] in_rm;
  logic [31:0] in_rs;
  logic        in_cflag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_b;
  logic        out_carry;

  modport slave (
    input  in_valid, in_imm, in_op2, in_rm, in_rs, in_cflag, out_ready,
    output in_ready, out_valid, out_b, out_carry
  );

  modport master (
    output in_valid, in_imm, in_op2, in_rm, in_rs, in_cflag, out_ready,
    input  in_ready, out_valid, out_b, out_carry
  );
endinterface

// File: rtl/operand_shifter.sv
// ARM7TDMI data-processing operand-2 stage: barrel shifter feeding ALU operand b
// and the shifter carry-out. Register-shift requests take one extra cycle.
module operand_shifter (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  operand_shifter_if.slave  bus
);

  typedef enum logic {IDLE, RS_WAIT} state_t;

  // Helpers below return {carry, result}.
  // Plain shift by 1..31; the carry is the last bit shifted out.
  function automatic logic [32:0] shift_n(input logic [1:0] typ, input logic [31:0] rm,
                                          input logic [4:0] n);
    logic [32:0] t;
    t = '0;
    case (typ)
      2'b00: t = {1'b0, rm} << n;
      2'b01: begin
        t = {rm, 1'b0} >> n;
        t = {t[0], t[32:1]};
      end
      2'b10: begin
        t = 33'($signed({rm, 1'b0}) >>> n);
        t = {t[0], t[32:1]};
      end
      default: begin
        t[31:0] = (rm >> n) | (rm << (6'd32 - {1'b0, n}));
        t[32]   = t[31];
      end
    endcase
    return t;
  endfunction

  function automatic logic [32:0] rot_imm(input logic [3:0] rot, input logic [7:0] imm8,
                                          input logic c);
    logic [4:0]  amt;
    logic [31:0] v;
    logic [31:0] r;
    amt = {rot, 1'b0};
    v   = {24'd0, imm8};
    r   = (v >> amt) | (v << (6'd32 - {1'b0, amt}));
    return (rot == 4'd0) ? {c, v} : {r[31], r};
  endfunction

  // An immediate amount of zero encodes LSR/ASR #32 and RRX.
  function automatic logic [32:0] shift_imm(input logic [1:0] typ, input logic [4:0] n,
                                            input logic [31:0] rm, input logic c);
    if (n != 5'd0) return shift_n(typ, rm, n);
    case (typ)
      2'b00:   return {c, rm};
      2'b01:   return {rm[31], 32'd0};
      2'b10:   return {rm[31], {32{rm[31]}}};
      default: return {rm[0], c, rm[31:1]};
    endcase
  endfunction

  function automatic logic [32:0] shift_reg(input logic [1:0] typ, input logic [7:0] s,
                                            input logic [31:0] rm, input logic c);
    if (s == 8'd0) return {c, rm};
    case (typ)
      2'b00: begin
        if (s < 8'd32)       return shift_n(typ, rm, s[4:0]);
        else if (s == 8'd32) return {rm[0], 32'd0};
        else                 return 33'd0;
      end
      2'b01: begin
        if (s < 8'd32)       return shift_n(typ, rm, s[4:0]);
        else if (s == 8'd32) return {rm[31], 32'd0};
        else                 return 33'd0;
      end
      2'b10: begin
        if (s < 8'd32)       return shift_n(typ, rm, s[4:0]);
        else                 return {rm[31], {32{rm[31]}}};
      end
      default: begin
        if (s[4:0] == 5'd0)  return {rm[31], rm};
        else                 return shift_n(typ, rm, s[4:0]);
      end
    endcase
  endfunction

  state_t      state_q, state_d;
  logic        in_ready_c, accept, is_reg;
  logic        capture, load_direct, load_rs;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_b_q;
  logic        out_carry_q;
  logic [1:0]  typ_q;
  logic [31:0] rm_q;
  logic [7:0]  rs_q;
  logic        c_q;
  logic [32:0] direct_res, rs_res;
  logic        unused_rs_hi;

  assign unused_rs_hi = ^bus.in_rs[31:8];

  assign is_reg     = !bus.in_imm && bus.in_op2[4];
  assign in_ready_c = (state_q == IDLE) && (!out_valid_q || bus.out_ready) && !flush;
  assign accept     = bus.in_valid && in_ready_c;

  assign direct_res = bus.in_imm
                    ? rot_imm(bus.in_op2[11:8], bus.in_op2[7:0], bus.in_cflag)
                    : shift_imm(bus.in_op2[6:5], bus.in_op2[11:7], bus.in_rm, bus.in_cflag);
  assign rs_res     = shift_reg(typ_q, rs_q, rm_q, c_q);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    capture     = 1'b0;
    load_direct = 1'b0;
    load_rs     = 1'b0;
    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_reg) begin
            capture = 1'b1;
            state_d = RS_WAIT;
          end else begin
            load_direct = 1'b1;
            out_valid_d = 1'b1;
          end
        end
      end
      default: begin
        load_rs     = 1'b1;
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
    endcase
    if (flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      load_rs     = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_b_q     <= '0;
      out_carry_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      if (load_direct)  {out_carry_q, out_b_q} <= direct_res;
      else if (load_rs) {out_carry_q, out_b_q} <= rs_res;
    end
  end

  // NOTE: operand capture registers are not reset; they are only read in RS_WAIT, after a capture.
  always_ff @(posedge clk) begin
    if (capture) begin
      typ_q <= bus.in_op2[6:5];
      rm_q  <= bus.in_rm;
      rs_q  <= bus.in_rs[7:0];
      c_q   <= bus.in_cflag;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_b     = out_b_q;
  assign bus.out_carry = out_carry_q;

endmodule

// File: doc/operand_shifter.md
# operand_shifter

Data-processing operand-2 stage of the ARM7TDMI core. It sits directly upstream of the ALU and produces the ALU's `b` operand plus the shifter carry-out. It decodes the 12-bit operand-2 field into one of three forms: rotated 8-bit immediate, register shifted by immediate, or register shifted by register. It applies ARM barrel-shifter semantics, including the special encodings, and delivers the result through a valid/ready handshake. The register-shift form takes one extra internal cycle, matching ARM7 I-cycle timing.

## Interface
- No parameters.
- `clk` in 1: core clock, all state updates on rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `flush` in 1: pipeline flush (taken branch/exception); discards in-flight and held work.
- `in_valid` in 1: upstream presents an operand request.
- `in_ready` out 1: stage can accept this cycle.
- `in_imm` in 1: instruction bit 25; 1 selects the rotated-immediate form.
- `in_op2` in 12: instruction bits [11:0].
- `in_rm` in 32: Rm value, already PC-adjusted upstream.
- `in_rs` in 32: Rs value; only bits [7:0] are used.
- `in_cflag` in 1: current CPSR C.
- `out_valid` out 1: `out_b`/`out_carry` valid.
- `out_ready` in 1: ALU consumes this cycle.
- `out_b` out 32: shifter operand to ALU `b`.
- `out_carry` out 1: shifter carry-out, for logical-op C update.

## Operation
- Immediate form (`in_imm`=1):
  - Result = zero-extended `op2[7:0]`, rotated right by 2·`op2[11:8]`.
  - Carry = `in_cflag` if rotate=0, else result[31].
- Shift type is `op2[6:5]`: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
- Immediate-shift form (`in_imm`=0, `op2[4]`=0). Amount n=`op2[11:7]`.
  - LSL #0: Rm, carry C.
  - LSL n: Rm<<n, carry Rm[32-n].
  - LSR #0 means LSR #32: result 0, carry Rm[31].
  - ASR #0 means ASR #32: all bits Rm[31], carry Rm[31].
  - ROR #0 means RRX: {C, Rm[31:1]}, carry Rm[0].
  - Otherwise LSR/ASR/ROR by n, carry = last bit shifted out (Rm[n-1]).
- Register-shift form (`in_imm`=0, `op2[4]`=1). Amount s=`in_rs[7:0]`.
  - s=0: Rm, carry C, for every type.
  - LSL: s<32 normal; s=32 gives 0, carry Rm[0]; s>32 gives 0, carry 0.
  - LSR: s<32 normal; s=32 gives 0, carry Rm[31]; s>32 gives 0, carry 0.
  - ASR: s≥32 gives all bits Rm[31], carry Rm[31].
  - ROR: s[4:0]=0 with s≠0 gives Rm, carry Rm[31]; otherwise ROR by s[4:0], carry Rm[s[4:0]-1].
- `op2[7]`=1 with `op2[4]`=1 is a multiply/extension encoding, excluded by upstream decode. The stage treats it as the register-shift form; behaviour is don't-care.
- FSM states:
  - IDLE: may accept.
  - RS_WAIT: register-shift captured, computing.
- Transitions:
  - IDLE→RS_WAIT on accepting a register-shift request.
  - RS_WAIT→IDLE after one cycle, loading the output register.
  - Immediate and immediate-shift forms stay in IDLE and load the output register directly.
- Request operands (`in_imm`, `in_op2`, `in_rm`, `in_rs[7:0]`, `in_cflag`) are latched on accept; later input changes are ignored.

## Timing
- `in_ready` = (state==IDLE) && (!out_valid || out_ready) && !flush.
- Accept = `in_valid` && `in_ready`.
- Immediate and immediate-shift forms: accept at edge k, `out_valid`=1 after edge k. Latency 1.
- Register-shift form: accept at edge k, RS_WAIT after edge k, `out_valid`=1 after edge k+1. Latency 2, `in_ready`=0 during RS_WAIT.
- Back-to-back: the output can be consumed and a new request accepted in the same cycle. Throughput is 1/cycle for non-register-shift forms.
- While `out_valid` && !`out_ready`: `out_b` and `out_carry` hold stable, no new accept.
- `out_valid` clears at the consuming edge unless a new result loads there.
- `flush`: at the next edge, `out_valid`=0 and state=IDLE. Any RS_WAIT work is dropped and nothing is accepted that cycle. `in_ready` is high the following cycle.
- Reset (including mid-RS_WAIT): state=IDLE, `out_valid`=0, `out_b`=0, `out_carry`=0. `in_ready` is 1 in the first cycle after reset deasserts.

## Test plan
- Immediate: op2=0x4FF (rot 4), C=0 → out_b=0xFF000000, carry=1, one cycle after accept. Then op2=0x0FF, C=1 → 0x000000FF, carry=1.
- Special immediate shifts:
  - LSR #0 (op2=0x020), Rm=0x80000001 → 0x00000000, carry=1.
  - ROR #0/RRX (op2=0x060), Rm=0x00000003, C=1 → 0x80000001, carry=1.
  - ASR #0 (op2=0x040), Rm=0x80000000 → 0xFFFFFFFF, carry=1.
- Register shifts, each with out_valid two cycles after accept and in_ready=0 for one cycle:
  - LSL (op2=0x310), Rm=1: Rs=0x20 → 0, carry=1; Rs=0x21 → 0, carry=0; Rs=0x100 → 1, carry=C.
  - ROR (op2=0x370), Rm=0x80000000, Rs=0x40 → 0x80000000, carry=1.
- Backpressure: hold out_ready=0 for 3 cycles with a result pending → out_b/out_carry stable, in_ready=0. Raise out_ready with in_valid=1 → consume and accept on the same edge, next result valid the following cycle.
- Flush during RS_WAIT: assert flush → out_valid stays 0, state IDLE, in_ready=1 the next cycle. A concurrent in_valid is not accepted.
- Reset mid-RS_WAIT → all outputs 0, no stale result appears afterward.
